address_register_unit: RTL
==========================

ADDRESS_REGISTER_UNIT -- requirements
Module: address_register_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset; sampled only on rising clk.
REQ-004 data_in  input  8  operand byte from data bus.
REQ-005 byte_valid  input  1  data_in holds an address byte this cycle; low byte first, then high byte.
REQ-006 abort  input  1  discard any partially assembled address.
REQ-007 pc_inc  input  1  advance PC by one.
REQ-008 pc_load  input  1  jump: copy MAR into PC.
REQ-009 mar_inc  input  1  advance MAR by one (second byte of two-byte memory operand).
REQ-010 pc_value  output  16  registered program counter.
REQ-011 mar_value  output  16  registered memory address register.
REQ-012 addr_ready  output  1  high while MAR holds a complete, freshly assembled address.
REQ-013 jump_err  output  1  sticky flag: pc_load received while addr_ready low.

Function
REQ-014 SHALL implement an assembly FSM with states A_EMPTY, A_LOW, A_FULL; addr_ready = 1 only in A_FULL.
REQ-015 A_EMPTY + byte_valid: capture data_in into internal low-byte holding register; next state A_LOW.
REQ-016 A_LOW + byte_valid: mar_value <= {data_in, held low byte} at that edge; next state A_FULL.
REQ-017 A_FULL + byte_valid: capture new low byte, next state A_LOW; mar_value retains old value until the high byte arrives.
REQ-018 No byte_valid: FSM holds state.
REQ-019 abort SHALL force next state A_EMPTY, discard the held low byte, and leave mar_value unchanged; abort overrides byte_valid in the same cycle.
REQ-020 mar_inc: mar_value <= mar_value + 1 mod 2^16 (FFFF -> 0000) in any FSM state; does not change FSM state.
REQ-021 mar_inc and high-byte completion in the same cycle: completion wins, increment dropped.
REQ-022 PC priority: reset > pc_load > pc_inc > hold.
REQ-023 pc_inc: pc_value <= pc_value + 1 mod 2^16 (FFFF -> 0000).
REQ-024 pc_load in A_FULL: pc_value <= current mar_value (pre-increment if mar_inc also asserted); next FSM state A_EMPTY unless byte_valid also asserted (then A_LOW per REQ-017).
REQ-025 pc_load outside A_FULL: PC unchanged (pc_inc also ignored that cycle), jump_err <= 1.
REQ-026 jump_err remains 1 until reset.
REQ-027 All outputs registered; every update visible one clk after the causing input is sampled; no combinational input-to-output path.

Reset
REQ-028 On reset: pc_value = 16'h0000, mar_value = 16'h0000, FSM = A_EMPTY, held low byte = 8'h00, addr_ready = 0, jump_err = 0.
REQ-029 Reset overrides all other inputs in the same cycle, including mid-assembly (A_LOW) and simultaneous pc_load.
REQ-030 First operation after reset release SHALL be accepted on the first rising edge with reset low.

Verification
REQ-031 Reset, then pc_inc for 3 cycles -> pc_value 0001, 0002, 0003 on successive edges; addr_ready 0.
REQ-032 byte_valid with 8'h34 then 8'h12 -> after second edge mar_value 1234, addr_ready 1; pc_load next cycle -> pc_value 1234, addr_ready 0, jump_err 0.
REQ-033 Preload MAR FFFF, mar_inc -> mar_value 0000; PC FFFF + pc_inc -> 0000.
REQ-034 byte_valid 8'hCD, then abort with byte_valid 8'hAB same cycle -> FSM A_EMPTY, mar_value unchanged, addr_ready 0.
REQ-035 pc_load with addr_ready 0 and pc_inc asserted -> pc_value unchanged, jump_err 1 and stays 1 until reset.
REQ-036 Reset asserted in A_LOW after low byte 8'h55 -> all outputs reset values; following bytes 8'h01, 8'h80 -> mar_value 8001.

Source files
------------

// File: rtl/address_register_unit.sv
// Address register unit: program counter plus a memory address register
// that is assembled from two operand bytes, low byte first.
module address_register_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        byte_valid,
  input  logic        abort,
  input  logic        pc_inc,
  input  logic        pc_load,
  input  logic        mar_inc,
  output logic [15:0] pc_value,
  output logic [15:0] mar_value,
  output logic        addr_ready,
  output logic        jump_err
);

  // state   | meaning
  // A_EMPTY | no address bytes held
  // A_LOW   | low byte held, waiting for high byte
  // A_FULL  | MAR holds a freshly assembled address
  localparam logic [1:0] A_EMPTY = 2'd0;
  localparam logic [1:0] A_LOW   = 2'd1;
  localparam logic [1:0] A_FULL  = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [7:0]  r_low;
  logic [15:0] r_pc;
  logic [15:0] r_mar;
  logic        r_jump_err;
  logic        w_byte;
  logic        w_complete;
  logic        w_jump_ok;

  assign w_byte     = byte_valid && !abort;
  assign w_complete = w_byte && (r_state == A_LOW);
  assign w_jump_ok  = pc_load && (r_state == A_FULL);

  // abort beats byte_valid; a new byte beats the post-jump return to A_EMPTY
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = A_EMPTY;
    end else if (byte_valid) begin
      w_state_nxt = (r_state == A_LOW) ? A_FULL : A_LOW;
    end else if (w_jump_ok) begin
      w_state_nxt = A_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= A_EMPTY;
      r_low      <= 8'h00;
      r_mar      <= 16'h0000;
      r_pc       <= 16'h0000;
      r_jump_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (abort) begin
        r_low <= 8'h00;
      end else if (w_byte && (r_state != A_LOW)) begin
        r_low <= data_in;
      end

      // completion wins over a same-cycle increment
      if (w_complete) begin
        r_mar <= {data_in, r_low};
      end else if (mar_inc) begin
        r_mar <= r_mar + 16'd1;
      end

      if (pc_load) begin
        if (w_jump_ok) begin
          r_pc <= r_mar;
        end else begin
          r_jump_err <= 1'b1;
        end
      end else if (pc_inc) begin
        r_pc <= r_pc + 16'd1;
      end
    end
  end

  assign pc_value   = r_pc;
  assign mar_value  = r_mar;
  assign addr_ready = (r_state == A_FULL);
  assign jump_err   = r_jump_err;

endmodule
